// File: rtl/bf16_pkg.sv
// Shared bfloat16 constants and arbiter state encoding.
package bf16_pkg;
    localparam int          BF16_W    = 16;
    localparam logic [15:0] BF16_ZERO = 16'h0000;
    localparam logic [15:0] BF16_ONE  = 16'h3F80;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;
endpackage

// File: rtl/bf16_mult_arbiter_if.sv
// Request bus from NPU lanes and the single valid/ready response port.
interface bf16_mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           rsp_result;
    logic                  rsp_ready;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/bf16_rr_arbiter.sv
// Round-robin pick: first requester after i_ptr, wrapping.
module bf16_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);
    logic [ID_W-1:0] w_c;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_c   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_c = ID_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_c]) begin
                o_any      = 1'b1;
                o_idx      = w_c;
                o_gnt[w_c] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bfloat16_mult.sv
// Combinational bfloat16 multiply: round-to-nearest-even,
// denormal inputs and underflow flushed to signed zero.
module bfloat16_mult
    import bf16_pkg::*;
(
    input  logic [BF16_W-1:0] i_a,
    input  logic [BF16_W-1:0] i_b,
    output logic [BF16_W-1:0] o_p
);
    logic        w_s;
    logic [7:0]  w_ea, w_eb;
    logic [6:0]  w_ma, w_mb;
    logic        w_za, w_zb, w_ia, w_ib, w_na, w_nb;
    logic [15:0] w_prod;
    logic [6:0]  w_mant;
    logic        w_g, w_st;
    logic [9:0]  w_exp;
    logic [16:0] w_rnd;

    assign w_s         = i_a[15] ^ i_b[15];
    assign {w_ea, w_ma} = i_a[14:0];
    assign {w_eb, w_mb} = i_b[14:0];
    assign w_za = (w_ea == 8'h00);
    assign w_zb = (w_eb == 8'h00);
    assign w_ia = (w_ea == 8'hFF) && (w_ma == 7'd0);
    assign w_ib = (w_eb == 8'hFF) && (w_mb == 7'd0);
    assign w_na = (w_ea == 8'hFF) && (w_ma != 7'd0);
    assign w_nb = (w_eb == 8'hFF) && (w_mb != 7'd0);

    assign w_prod = 16'({1'b1, w_ma}) * 16'({1'b1, w_mb});

    always_comb begin
        if (w_prod[15]) begin
            w_mant = w_prod[14:8];
            w_g    = w_prod[7];
            w_st   = |w_prod[6:0];
        end else begin
            w_mant = w_prod[13:7];
            w_g    = w_prod[6];
            w_st   = |w_prod[5:0];
        end
    end

    // exponent stays two's complement so under/overflow is a signed compare
    assign w_exp = {2'b00, w_ea} + {2'b00, w_eb} - 10'd127
                 + {9'd0, w_prod[15]};
    assign w_rnd = {w_exp, w_mant}
                 + {16'd0, w_g & (w_st | w_mant[0])};

    always_comb begin
        o_p = {w_s, w_rnd[14:0]};
        if (w_na || w_nb || (w_ia && w_zb) || (w_ib && w_za))
            o_p = BF16_QNAN;
        else if (w_ia || w_ib)
            o_p = {w_s, 8'hFF, 7'd0};
        else if (w_za || w_zb)
            o_p = {w_s, BF16_ZERO[14:0]};
        else if ($signed(w_rnd[16:7]) >= 10'sd255)
            o_p = {w_s, 8'hFF, 7'd0};
        else if ($signed(w_rnd[16:7]) <= 10'sd0)
            o_p = {w_s, BF16_ZERO[14:0]};
    end
endmodule

// File: rtl/bf16_mult_arbiter.sv
// Shares one bfloat16_mult among NUM_REQ requesters, round-robin.
// Define BF16_ARB_STATS_EN for per-requester grant counters.
module bf16_mult_arbiter
    import bf16_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef BF16_ARB_STATS_EN
    input  logic                  stat_clear,
    output logic [32*NUM_REQ-1:0] stat_grants,
`endif
    bf16_mult_arbiter_if.slave    bus
);
    arb_state_e         r_state, w_state_nxt;
    logic [ID_W-1:0]    r_ptr, r_id;
    logic [BF16_W-1:0]  r_result;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_idx;
    logic               w_any, w_can_accept, w_fire;
    logic [BF16_W-1:0]  w_a, w_b, w_prod;

    bf16_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_a = bus.req_a[BF16_W*w_idx +: BF16_W];
    assign w_b = bus.req_b[BF16_W*w_idx +: BF16_W];

    bfloat16_mult u_mul (
        .i_a (w_a),
        .i_b (w_b),
        .o_p (w_prod)
    );

    // reset masks the grant so no operand is consumed and then dropped
    assign w_can_accept  = !reset && ((r_state == IDLE) || bus.rsp_ready);
    assign w_fire        = w_any && w_can_accept;
    assign bus.req_ready = w_can_accept ? w_gnt : '0;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_fire) w_state_nxt = HOLD;
            HOLD: if (bus.rsp_ready && !w_fire) w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ptr    <= ID_W'(NUM_REQ - 1);
            r_id     <= '0;
            r_result <= BF16_ZERO;
        end else begin
            r_state <= w_state_nxt;
            if (w_fire) begin
                r_ptr    <= w_idx;
                r_id     <= w_idx;
                r_result <= w_prod;
            end
        end
    end

    assign bus.rsp_valid  = (r_state == HOLD);
    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_result;

`ifdef BF16_ARB_STATS_EN
    logic [31:0] r_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset || stat_clear)
                r_cnt[i] <= '0;
            else if (w_fire && w_gnt[i])
                r_cnt[i] <= r_cnt[i] + 32'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        assign stat_grants[32*gi +: 32] = r_cnt[gi];
    end
`endif
endmodule
